// File: rtl/seq_detector.sv
// Assembles SEQ_LEN button presses into an entry, compares it with SEQ_PATTERN and
// reports match/mismatch/timeout pulses plus a timed LED result window.
module seq_detector #(
  parameter int                  SEQ_LEN     = 4,
  parameter logic [SEQ_LEN-1:0]  SEQ_PATTERN = 4'b1011,
  parameter int                  TOUT_TICKS  = 8,
  parameter int                  SHOW_TICKS  = 4,
  parameter int                  CNT_WIDTH   = 4,
  localparam int                 BIT_W       = $clog2(SEQ_LEN + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE,
  input  logic                 BTN0_CE,
  input  logic                 BTN1_CE,
  output logic                 DET,
  output logic                 ERR,
  output logic                 TOUT,
  output logic                 MATCH_LED,
  output logic                 FAIL_LED,
  output logic                 BUSY,
  output logic [BIT_W-1:0]     BIT_CNT,
  output logic [CNT_WIDTH-1:0] MATCH_CNT,
  output logic [1:0]           STATE
);

  localparam int TICK_MAX = (TOUT_TICKS > SHOW_TICKS) ? TOUT_TICKS : SHOW_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_SHOW    = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [SEQ_LEN-2:0]   shift_q, shift_n;
  logic [BIT_W-1:0]     bit_q, bit_n;
  logic [TICK_W-1:0]    tick_q, tick_n;
  logic [CNT_WIDTH-1:0] mcnt_q, mcnt_n;
  logic                 det_n, err_n, tout_n, mled_n, fled_n;
  logic                 valid, bit_in;
  logic [SEQ_LEN-1:0]   word;

  // Simultaneous presses of both buttons carry no information and are dropped.
  assign valid  = BTN0_CE ^ BTN1_CE;
  assign bit_in = BTN1_CE;
  assign word   = {shift_q, bit_in};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      tick_q    <= '0;
      mcnt_q    <= '0;
      DET       <= 1'b0;
      ERR       <= 1'b0;
      TOUT      <= 1'b0;
      MATCH_LED <= 1'b0;
      FAIL_LED  <= 1'b0;
    end else begin
      state     <= state_n;
      shift_q   <= shift_n;
      bit_q     <= bit_n;
      tick_q    <= tick_n;
      mcnt_q    <= mcnt_n;
      DET       <= det_n;
      ERR       <= err_n;
      TOUT      <= tout_n;
      MATCH_LED <= mled_n;
      FAIL_LED  <= fled_n;
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift_q;
    bit_n   = bit_q;
    tick_n  = tick_q;
    mcnt_n  = mcnt_q;
    det_n   = 1'b0;
    err_n   = 1'b0;
    tout_n  = 1'b0;
    mled_n  = MATCH_LED;
    fled_n  = FAIL_LED;
    case (state)
      S_IDLE: begin
        tick_n = '0;
        if (valid) begin
          shift_n    = '0;
          shift_n[0] = bit_in;
          bit_n      = BIT_W'(1);
          state_n    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A press on the same cycle as the final timeout tick keeps the entry alive.
        if (valid) begin
          tick_n = '0;
          if (bit_q == BIT_W'(SEQ_LEN - 1)) begin
            state_n = S_SHOW;
            shift_n = '0;
            bit_n   = '0;
            if (word == SEQ_PATTERN) begin
              det_n  = 1'b1;
              mled_n = 1'b1;
              fled_n = 1'b0;
              if (mcnt_q != '1) mcnt_n = mcnt_q + CNT_WIDTH'(1);
            end else begin
              err_n  = 1'b1;
              mled_n = 1'b0;
              fled_n = 1'b1;
            end
          end else begin
            shift_n = word[SEQ_LEN-2:0];
            bit_n   = bit_q + BIT_W'(1);
          end
        end else if (CE) begin
          if (tick_q == TICK_W'(TOUT_TICKS - 1)) begin
            state_n = S_IDLE;
            tout_n  = 1'b1;
            shift_n = '0;
            bit_n   = '0;
            tick_n  = '0;
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end
      end
      S_SHOW: begin
        if (CE) begin
          if (tick_q == TICK_W'(SHOW_TICKS - 1)) begin
            state_n = S_IDLE;
            mled_n  = 1'b0;
            fled_n  = 1'b0;
            tick_n  = '0;
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tick_n  = '0;
      end
    endcase
  end

  assign BUSY      = (state != S_IDLE);
  assign BIT_CNT   = bit_q;
  assign MATCH_CNT = mcnt_q;
  assign STATE     = state;

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: a behavioural reference predicts every output each cycle,
// expectations are queued as stimulus is driven and popped after the clock edge.
module tb_seq_detector;

  localparam int W = 15;

  logic       CLK = 1'b0;
  logic       RST, CE, BTN0_CE, BTN1_CE;
  logic       DET, ERR, TOUT, MATCH_LED, FAIL_LED, BUSY;
  logic [2:0] BIT_CNT;
  logic [3:0] MATCH_CNT;
  logic [1:0] STATE;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference state: mode 0 idle, 1 collect, 2 show
  int m_mode, m_bits, m_val, m_tick, m_mcnt;
  bit m_det, m_err, m_tout, m_mled, m_fled;

  seq_detector dut (
    .CLK(CLK), .RST(RST), .CE(CE), .BTN0_CE(BTN0_CE), .BTN1_CE(BTN1_CE),
    .DET(DET), .ERR(ERR), .TOUT(TOUT), .MATCH_LED(MATCH_LED), .FAIL_LED(FAIL_LED),
    .BUSY(BUSY), .BIT_CNT(BIT_CNT), .MATCH_CNT(MATCH_CNT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit b0, input bit b1, input bit ce, input bit rst);
    m_det = 0; m_err = 0; m_tout = 0;
    if (rst) begin
      m_mode = 0; m_bits = 0; m_val = 0; m_tick = 0; m_mcnt = 0;
      m_mled = 0; m_fled = 0;
    end else if (m_mode == 0) begin
      if (b0 != b1) begin
        m_mode = 1; m_val = int'(b1); m_bits = 1; m_tick = 0;
      end
    end else if (m_mode == 1) begin
      if (b0 != b1) begin
        m_val = m_val * 2 + int'(b1);
        m_bits++;
        m_tick = 0;
        if (m_bits == 4) begin
          if (m_val == 11) begin
            m_det = 1; m_mled = 1; m_fled = 0;
            if (m_mcnt < 15) m_mcnt++;
          end else begin
            m_err = 1; m_mled = 0; m_fled = 1;
          end
          m_mode = 2; m_bits = 0; m_val = 0;
        end
      end else if (ce) begin
        m_tick++;
        if (m_tick == 8) begin
          m_tout = 1; m_mode = 0; m_bits = 0; m_val = 0; m_tick = 0;
        end
      end
    end else begin
      if (ce) begin
        m_tick++;
        if (m_tick == 4) begin
          m_mode = 0; m_tick = 0; m_mled = 0; m_fled = 0;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    return {2'(m_mode), m_det, m_err, m_tout, m_mled, m_fled, (m_mode != 0),
            3'(m_bits), 4'(m_mcnt)};
  endfunction

  // One clock: drive, predict, advance, compare against the oldest expectation.
  task automatic cyc(input bit b0, input bit b1, input bit ce, input bit rst);
    logic [W-1:0] exp;
    BTN0_CE = b0; BTN1_CE = b1; CE = ce; RST = rst;
    model_step(b0, b1, ce, rst);
    exp_q.push_back(model_vec());
    @(posedge CLK);
    @(negedge CLK);
    exp = exp_q.pop_front();
    check("outputs", {STATE, DET, ERR, TOUT, MATCH_LED, FAIL_LED, BUSY, BIT_CNT, MATCH_CNT},
          exp);
  endtask

  task automatic press(input bit v, input bit ce);
    cyc(!v, v, ce, 1'b0);
  endtask

  task automatic entry(input logic [3:0] pat);
    for (int i = 3; i >= 0; i--) press(pat[i], 1'b1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    RST = 1'b1; CE = 1'b0; BTN0_CE = 1'b0; BTN1_CE = 1'b0;
    @(negedge CLK);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    check("reset_outputs", {STATE, DET, ERR, TOUT, MATCH_LED, FAIL_LED, BUSY, BIT_CNT, MATCH_CNT}, 0);

    // 1: matching entry
    press(1, 1); press(0, 1); press(1, 1); press(1, 1);
    check("t1_det", DET, 1);
    check("t1_match_led", MATCH_LED, 1);
    check("t1_match_cnt", MATCH_CNT, 1);
    ticks(4);
    check("t1_idle", BUSY, 0);

    // 2: mismatching entry, LED held for four CE ticks with gaps in CE
    entry(4'b1001);
    check("t2_err", ERR, 1);
    check("t2_fail_led", FAIL_LED, 1);
    cyc(0, 0, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    ticks(2);
    check("t2_led_still_on", FAIL_LED, 1);
    ticks(1);
    check("t2_led_off", FAIL_LED, 0);
    check("t2_match_cnt", MATCH_CNT, 1);

    // 3: timeout after 8 CE ticks, presses without CE still accepted
    press(1, 0); press(0, 0);
    cyc(0, 0, 0, 0);
    ticks(7);
    check("t3_no_tout_yet", TOUT, 0);
    ticks(1);
    check("t3_tout", TOUT, 1);
    check("t3_bit_cnt", BIT_CNT, 0);
    check("t3_busy", BUSY, 0);

    // 4: both buttons ignored; press on the final timeout tick keeps the entry
    press(1, 1);
    cyc(1, 1, 1, 0);
    check("t4_bit_cnt_hold", BIT_CNT, 1);
    ticks(6);
    press(0, 1);
    check("t4_no_tout", TOUT, 0);
    check("t4_bit_cnt", BIT_CNT, 2);
    ticks(7);
    press(1, 1); press(1, 1);
    check("t4_det", DET, 1);

    // 5: presses during SHOW ignored, counter saturates
    press(1, 1); press(0, 0);
    ticks(3);
    check("t5_show_idle", BUSY, 0);
    for (int k = 0; k < 16; k++) begin
      entry(4'b1011);
      ticks(4);
    end
    check("t5_saturated", MATCH_CNT, 15);

    // 6: reset mid-entry
    press(1, 1); press(0, 1); press(1, 1);
    cyc(0, 0, 1, 1);
    check("t6_reset_outputs", {STATE, DET, ERR, TOUT, MATCH_LED, FAIL_LED, BUSY, BIT_CNT, MATCH_CNT}, 0);
    entry(4'b1011);
    check("t6_det", DET, 1);
    ticks(4);

    // randomized traffic against the reference
    for (int i = 0; i < 600; i++) begin
      int r;
      bit b0, b1, ce, rst;
      r   = $urandom_range(0, 9);
      b0  = (r < 2) || (r == 4);
      b1  = (r == 2) || (r == 3) || (r == 4);
      ce  = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 199) == 0);
      cyc(b0, b1, ce, rst);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
